// File: rtl/knight_anim_pkg.sv
// rtl/knight_anim_pkg.sv - shared types and default sprite constants for the knight animation block
package knight_anim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        TURN = 2'd2
    } anim_state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } dir_t;

    localparam int KNIGHT_W           = 50;
    localparam int KNIGHT_H           = 64;
    localparam int KNIGHT_FRAMES      = 4;
    localparam int KNIGHT_FRAME_TICKS = 6;
    localparam int KNIGHT_ADDR_W      = 12;

endpackage

// File: rtl/knight_pix_addr.sv
// rtl/knight_pix_addr.sv - registered sprite hit test and mirrored frame ROM address
module knight_pix_addr import knight_anim_pkg::*; #(
    parameter int SPRITE_W = KNIGHT_W,
    parameter int SPRITE_H = KNIGHT_H,
    parameter int ADDR_W   = KNIGHT_ADDR_W
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        knight_x,
    input  logic [9:0]        knight_y,
    input  logic              facing_left,
    output logic [ADDR_W-1:0] rom_address,
    output logic              sprite_on
);

    logic [9:0]        dx;
    logic [9:0]        dy;
    logic [9:0]        col;
    logic              hit;
    logic [ADDR_W-1:0] rom_address_d;
    logic [ADDR_W-1:0] rom_address_q;
    logic              sprite_on_d;
    logic              sprite_on_q;

    // Pixels left of / above the sprite wrap to large offsets and fail the range test.
    always_comb begin
        dx            = DrawX - knight_x;
        dy            = DrawY - knight_y;
        hit           = (dx < 10'(SPRITE_W)) && (dy < 10'(SPRITE_H));
        col           = facing_left ? (10'(SPRITE_W - 1) - dx) : dx;
        sprite_on_d   = hit;
        rom_address_d = hit ? (ADDR_W'(dy) * ADDR_W'(SPRITE_W) + ADDR_W'(col)) : '0;
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rom_address_q <= '0;
            sprite_on_q   <= 1'b0;
        end else begin
            rom_address_q <= rom_address_d;
            sprite_on_q   <= sprite_on_d;
        end
    end

    assign rom_address = rom_address_q;
    assign sprite_on   = sprite_on_q;

endmodule

// File: rtl/knight_anim_ctrl.sv
// rtl/knight_anim_ctrl.sv - per-frame knight walk sequencer and sprite ROM address generator
module knight_anim_ctrl import knight_anim_pkg::*; #(
    parameter int SPRITE_W    = KNIGHT_W,
    parameter int SPRITE_H    = KNIGHT_H,
    parameter int NUM_FRAMES  = KNIGHT_FRAMES,
    parameter int FRAME_TICKS = KNIGHT_FRAME_TICKS,
    parameter int ADDR_W      = KNIGHT_ADDR_W
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              vsync,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        knight_x,
    input  logic [9:0]        knight_y,
    input  logic              move_left,
    input  logic              move_right,
    output logic [1:0]        frame_sel,
    output logic              facing_left,
    output logic [ADDR_W-1:0] rom_address,
    output logic              sprite_on,
    output logic [1:0]        anim_state
);

    logic        vsync_d, vsync_q;
    logic        tick;
    dir_t        dir;
    logic        same_dir, opp_dir;
    anim_state_t state_d, state_q;
    logic [1:0]  frame_d, frame_q;
    logic        facing_d, facing_q;
    logic [7:0]  cnt_d, cnt_q;

    always_comb begin
        vsync_d = vsync;
        tick    = vsync_q & ~vsync;

        if (move_left && !move_right)      dir = LEFT;
        else if (move_right && !move_left) dir = RIGHT;
        else                               dir = NONE;

        same_dir = (dir == LEFT && facing_q) || (dir == RIGHT && !facing_q);
        opp_dir  = (dir != NONE) && !same_dir;

        state_d  = state_q;
        frame_d  = frame_q;
        facing_d = facing_q;
        cnt_d    = cnt_q;

        // Everything holds between ticks so the shown frame never changes mid-picture.
        if (tick) begin
            case (state_q)
                IDLE, TURN: begin
                    cnt_d = 8'd0;
                    if (same_dir) begin
                        state_d = WALK;
                        frame_d = 2'd1;
                    end else if (opp_dir) begin
                        state_d  = TURN;
                        facing_d = ~facing_q;
                        frame_d  = 2'd0;
                    end else begin
                        state_d = IDLE;
                        frame_d = 2'd0;
                    end
                end
                WALK: begin
                    if (same_dir) begin
                        if (cnt_q == 8'(FRAME_TICKS - 1)) begin
                            cnt_d   = 8'd0;
                            frame_d = (frame_q == 2'(NUM_FRAMES - 1)) ? 2'd1 : frame_q + 2'd1;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else if (opp_dir) begin
                        state_d  = TURN;
                        facing_d = ~facing_q;
                        frame_d  = 2'd0;
                        cnt_d    = 8'd0;
                    end else begin
                        state_d = IDLE;
                        frame_d = 2'd0;
                        cnt_d   = 8'd0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    frame_d = 2'd0;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            vsync_q  <= 1'b0;
            state_q  <= IDLE;
            frame_q  <= 2'd0;
            facing_q <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            vsync_q  <= vsync_d;
            state_q  <= state_d;
            frame_q  <= frame_d;
            facing_q <= facing_d;
            cnt_q    <= cnt_d;
        end
    end

    assign frame_sel   = frame_q;
    assign facing_left = facing_q;
    assign anim_state  = state_q;

    knight_pix_addr #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .ADDR_W   (ADDR_W)
    ) u_pix_addr (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .knight_x    (knight_x),
        .knight_y    (knight_y),
        .facing_left (facing_q),
        .rom_address (rom_address),
        .sprite_on   (sprite_on)
    );

endmodule
